// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the seven-segment display family.
//   HEX_SEG_TABLE : active-low g..a patterns for hex digits 0..F
//   SEG_BLANK     : all segments and dp off (active low)
//   idx_width()   : counter/index width for a modulus n (at least 1 bit)
package seg_scan_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Width needed to hold values 0..n-1; a modulus of 1 still gets one bit.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/seg_scan_display_hex_to_seg.sv
// Combinational hex nibble + decimal point to active-low segment pattern.
//   nibble : hex value 0..F
//   dp     : decimal point on, active high
//   seg    : bit 7 = dp (active low), bits 6:0 = g..a (active low)
module hex_to_seg
  import seg_scan_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Table lookup with the dp bit inverted onto bit 7.
  always_comb begin
    seg = {~dp, HEX_SEG_TABLE[nibble]};
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scan controller.
//   clk, rst     : system clock, synchronous active-high reset
//   data_in      : packed hex nibbles, nibble i drives digit i (0 = rightmost)
//   dp_in        : per-digit decimal point, active high
//   blank_mask   : per-digit force dark
//   blink_mask   : per-digit dark while blink phase is 1
//   lz_suppress  : darken leading zero digits (digit 0 always kept)
//   brightness   : PWM duty, all-ones = full on, zero = dark
//   an           : digit enables, active low (registered)
//   seg          : segments, active low, bit 7 = dp (registered)
//   frame_sync   : one-cycle pulse as digit 0 of a new frame is shown
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100_000,
  parameter int PWM_BITS     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_suppress,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_sync
);

  localparam int IDX_W = idx_width(DIGITS);
  localparam int PRE_W = idx_width(SCAN_DIV);
  localparam int FRM_W = idx_width(BLINK_FRAMES);

  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1'b1);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1'b1);
  localparam logic [FRM_W-1:0]    FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [FRM_W-1:0]    FRM_ONE  = FRM_W'(1'b1);
  localparam logic [PWM_BITS-1:0] PWM_FULL = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1'b1);

  logic [PRE_W-1:0]    pre_q,         pre_d;
  logic [IDX_W-1:0]    idx_q,         idx_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,     pwm_cnt_d;
  logic [FRM_W-1:0]    frame_cnt_q,   frame_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                vis_q,         vis_d;
  logic [DIGITS-1:0]   an_q,          an_d;
  logic [7:0]          seg_q,         seg_d;
  logic                frame_sync_q,  frame_sync_d;

  logic                tick;
  logic                wrap;
  logic                lz_run;
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          new_nibble;
  logic                new_dp;
  logic                new_vis;
  logic [7:0]          new_seg;
  logic                pwm_on;

  // Leading-zero priority chain: a digit is dark while it and every digit above it read zero.
  always_comb begin
    lz_mask = '0;
    lz_run  = lz_suppress;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (data_in[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_run;
    end
  end

  // Prescaler, digit index, PWM counter and blink frame counter next state.
  always_comb begin
    tick = (pre_q == PRE_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    if (tick) begin
      pre_d = '0;
      idx_d = wrap ? '0 : (idx_q + IDX_ONE);
    end else begin
      pre_d = pre_q + PRE_ONE;
      idx_d = idx_q;
    end

    // The counter restarts each slot so every digit gets the same duty window.
    if (tick) begin
      pwm_cnt_d = '0;
    end else if (pwm_cnt_q == PWM_FULL) begin
      pwm_cnt_d = pwm_cnt_q;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    end

    if (wrap && (frame_cnt_q == FRM_LAST)) begin
      frame_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else if (wrap) begin
      frame_cnt_d   = frame_cnt_q + FRM_ONE;
      blink_phase_d = blink_phase_q;
    end else begin
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
    end
  end

  // Pick nibble, dp and visibility of the digit that idx is about to point at.
  always_comb begin
    new_nibble = 4'h0;
    new_dp     = 1'b0;
    new_vis    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      new_nibble = (idx_d == IDX_W'(i)) ? data_in[4*i +: 4] : new_nibble;
      new_dp     = (idx_d == IDX_W'(i)) ? dp_in[i] : new_dp;
      // The blink phase that applies is the one in force for the frame being entered.
      new_vis    = (idx_d == IDX_W'(i)) ?
                   (~blank_mask[i] & ~lz_mask[i] & ~(blink_mask[i] & blink_phase_d)) :
                   new_vis;
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (new_nibble),
    .dp     (new_dp),
    .seg    (new_seg)
  );

  // Output next state; brightness is applied every cycle from next-state counters.
  always_comb begin
    if (tick) begin
      seg_d = new_seg;
      vis_d = new_vis;
    end else begin
      seg_d = seg_q;
      vis_d = vis_q;
    end

    pwm_on = (brightness == PWM_FULL) || (pwm_cnt_d < brightness);

    an_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      an_d[i] = ~((idx_d == IDX_W'(i)) & vis_d & pwm_on);
    end

    frame_sync_d = wrap;
  end

  // State and output registers with synchronous reset overriding the scan tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q         <= '0;
      idx_q         <= IDX_LAST;
      pwm_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      vis_q         <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      frame_sync_q  <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      vis_q         <= vis_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_sync_q  <= frame_sync_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed self-checking bench for seg_scan_display with
// DIGITS=4, SCAN_DIV=4, PWM_BITS=2, BLINK_FRAMES=2.
module tb_seg_scan_display;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_sync;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_display #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .PWM_BITS     (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .blink_mask  (blink_mask),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .an          (an),
    .seg         (seg),
    .frame_sync  (frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, where outputs are sampled and inputs driven.
  task automatic step();
    @(negedge clk);
  endtask

  // Move one full slot forward and check the digit that is then shown.
  task automatic slot(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
    repeat (4) step();
    check({tag, "_an"}, {4'h0, an}, {4'h0, exp_an});
    check({tag, "_seg"}, seg, exp_seg);
  endtask

  logic [3:0] scan_an  [4];
  logic [7:0] scan_seg [4];
  logic [3:0] bri_an   [8];
  logic [3:0] blink_an [5];
  int         fs_cnt;

  initial begin
    scan_an  = '{4'hD, 4'hB, 4'h7, 4'hE};
    scan_seg = '{8'h88, 8'hA4, 8'hF9, 8'h8E};
    bri_an   = '{4'hF, 4'hF, 4'hF, 4'hD, 4'hF, 4'hF, 4'hF, 4'hB};
    blink_an = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hF};

    rst         = 1'b1;
    data_in     = 16'h12AF;
    dp_in       = 4'b0000;
    blank_mask  = 4'b0000;
    blink_mask  = 4'b0000;
    lz_suppress = 1'b0;
    brightness  = 2'd3;

    // Reset and first slot.
    repeat (3) step();
    rst = 1'b0;
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_seg", seg, 8'hFF);
    check("rst_fs", {7'h0, frame_sync}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("pre_an", {4'h0, an}, 8'h0F);
      check("pre_seg", seg, 8'hFF);
    end
    step();
    check("first_an", {4'h0, an}, 8'h0E);
    check("first_seg", seg, 8'h8E);
    check("first_fs", {7'h0, frame_sync}, 8'h01);

    // Scan order over one frame, counting frame_sync pulses.
    fs_cnt = 0;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        fs_cnt += int'(frame_sync);
      end
      check("scan_an", {4'h0, an}, {4'h0, scan_an[s]});
      check("scan_seg", seg, scan_seg[s]);
    end
    check("fs_count", 8'(fs_cnt), 8'd1);
    check("fs_wrap", {7'h0, frame_sync}, 8'h01);

    // Leading-zero suppression.
    data_in     = 16'h0050;
    lz_suppress = 1'b1;
    slot("lz_d1", 4'hD, 8'h92);
    slot("lz_d2", 4'hF, 8'hC0);
    slot("lz_d3", 4'hF, 8'hC0);
    slot("lz_d0", 4'hE, 8'hC0);

    // Decimal point then blanking.
    dp_in = 4'b0010;
    slot("dp_d1", 4'hD, 8'h12);
    blank_mask = 4'b0001;
    slot("bl_d2", 4'hF, 8'hC0);
    slot("bl_d3", 4'hF, 8'hC0);
    slot("bl_d0", 4'hF, 8'hC0);

    // Brightness: 1 lights only the first cycle of each slot, 0 never, 3 always.
    data_in     = 16'h12AF;
    lz_suppress = 1'b0;
    blank_mask  = 4'b0000;
    dp_in       = 4'b0000;
    brightness  = 2'd1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("bri1_an", {4'h0, an}, {4'h0, bri_an[c]});
    end
    brightness = 2'd0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("bri0_an", {4'h0, an}, 8'h0F);
    end
    brightness = 2'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bri3_an", {4'h0, an}, 8'h07);
    end
    step();
    check("bri3_d0", {4'h0, an}, 8'h0E);

    // Mid-slot reset at pre=2 of digit 2.
    repeat (8) step();
    check("pre_rst_an", {4'h0, an}, 8'h0B);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_an", {4'h0, an}, 8'h0F);
    check("mrst_seg", seg, 8'hFF);
    check("mrst_fs", {7'h0, frame_sync}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_wait_an", {4'h0, an}, 8'h0F);
    end
    step();
    check("mrst_d0_an", {4'h0, an}, 8'h0E);
    check("mrst_d0_seg", seg, 8'h8E);
    check("mrst_d0_fs", {7'h0, frame_sync}, 8'h01);

    // Blink: digit 0 alternates dark/lit every two frames.
    blink_mask = 4'b0001;
    for (int f = 0; f < 5; f++) begin
      repeat (16) step();
      check("blink_d0", {4'h0, an}, {4'h0, blink_an[f]});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
